reg_file: RTL
=============

Name: reg_file

Overview:
- Operand register file for the 16-bit single-cycle MIPS datapath.
- Sits directly upstream of the ALU: read port 1 drives ALU src1, and read port 2 drives the src2 mux that selects between this port and the immediate.
- Captures the writeback value (ALU result or memory load data) at the clock edge that ends each instruction.
- Register 0 is hardwired to zero, per MIPS convention.

Parameters:
- DATA_WIDTH, 16, width of each register and data port.
- ADDR_WIDTH, 3, register address width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- reg_write_en  input  1  writeback enable for the current instruction.
- reg_write_dest  input  ADDR_WIDTH  destination register index.
- reg_write_data  input  DATA_WIDTH  writeback value.
- reg_read_addr_1  input  ADDR_WIDTH  source register 1 index (rs).
- reg_read_data_1  output  DATA_WIDTH  source register 1 value, to ALU src1.
- reg_read_addr_2  input  ADDR_WIDTH  source register 2 index (rt).
- reg_read_data_2  output  DATA_WIDTH  source register 2 value, to ALU src2 mux / store data.
- dbg_read_addr  input  ADDR_WIDTH  debug/testbench inspection index.
- dbg_read_data  output  DATA_WIDTH  debug port value.

Behaviour:
- Storage: NUM_REGS x DATA_WIDTH flip-flops, not inferred RAM. Asynchronous clear is required.
- Reset:
  - rst_n low clears all registers to 0 immediately, independent of clk.
  - While rst_n is low, writes are ignored and all read outputs equal 0.
  - Reset release is synchronised externally. The first write may occur at the first rising edge with rst_n high.
- Reads:
  - All three read ports are purely combinational.
  - Each port returns the currently stored value of the addressed register, with zero-cycle latency.
  - Index 0 always returns 0, regardless of storage contents.
- Write:
  - On rising clk with rst_n high, reg_write_en=1 and reg_write_dest!=0: regs[reg_write_dest] <= reg_write_data.
  - The new value becomes visible on the read ports after the edge, not before.
- Write to r0: reg_write_en=1 with reg_write_dest=0 is accepted as a no-op. r0 storage stays 0 and no other register changes.
- reg_write_en=0: no register changes, whatever the dest/data inputs are.
- Read-during-write, same index:
  - In the cycle the write is pending, the read port returns the OLD value. There is no write-through bypass.
  - Bypassing is prohibited: in the single-cycle datapath, write data derives from read data through the ALU, so a bypass would form a combinational loop.
- Read addresses:
  - Both source ports may address the same register; both then return the same value.
  - All ports are independent of one another.
- Reset mid-operation: asserting rst_n in the same cycle as a write clears everything. The write is lost and does not land after reset releases.
- Width rules:
  - No sign handling: data is stored and returned bit-exact.
  - Addresses are full-range; with NUM_REGS=2**ADDR_WIDTH, no out-of-range index exists.
- Timing: read-to-output is a single mux level per port. Write-enable decode is one-hot per register.

Test Plan:
- Reset clear: write 16'hFFFF to r1..r7, pulse rst_n low mid-cycle -> all read/dbg ports show 16'h0000 immediately. After release, every register still reads 0.
- Basic write/read: write r3=16'h1234 and r5=16'hABCD on successive edges; set read_addr_1=3, read_addr_2=5 -> outputs 16'h1234 and 16'hABCD. dbg_read_addr=5 -> 16'hABCD.
- r0 hardwire: reg_write_en=1, dest=0, data=16'hBEEF -> read of r0 on all ports = 16'h0000. r1..r7 are unchanged (check via dbg sweep).
- Read-during-write: r2 holds 16'h0007; present a write of r2=16'h0009 with read_addr_1=2 -> before the edge, read_data_1=16'h0007; after the edge, 16'h0009.
- Write-enable gating: reg_write_en=0, dest=4, data=16'h5555 for 3 edges -> r4 retains its prior value 16'h0000.
- ALU loop (with alu instantiated, add select): r1=16'h7FFF, r2=16'h0001, loop rd=r1, rs=r1, rt=r2, add -> r1 becomes 16'h8000 after one edge and 16'h8001 after two. No combinational loop is reported by lint or sim.

Source files
------------

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - writeback, operand-read and debug-read bundle for the register file
interface reg_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] reg_write_dest;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic [ADDR_WIDTH-1:0] reg_read_addr_1;
    logic [DATA_WIDTH-1:0] reg_read_data_1;
    logic [ADDR_WIDTH-1:0] reg_read_addr_2;
    logic [DATA_WIDTH-1:0] reg_read_data_2;
    logic [ADDR_WIDTH-1:0] dbg_read_addr;
    logic [DATA_WIDTH-1:0] dbg_read_data;

    modport master (
        output reg_write_en, reg_write_dest, reg_write_data,
        output reg_read_addr_1, reg_read_addr_2, dbg_read_addr,
        input  reg_read_data_1, reg_read_data_2, dbg_read_data
    );

    modport slave (
        input  reg_write_en, reg_write_dest, reg_write_data,
        input  reg_read_addr_1, reg_read_addr_2, dbg_read_addr,
        output reg_read_data_1, reg_read_data_2, dbg_read_data
    );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8x16 flop-based operand register file with r0 hardwired to zero
module reg_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input logic        clk,
    input logic        rst_n,
    reg_file_if.slave  bus
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel;

    // One-hot write decode; bit 0 is forced low so r0 storage never changes.
    always_comb begin
        wr_sel = '0;
        if (bus.reg_write_en) begin
            wr_sel[bus.reg_write_dest] = 1'b1;
        end
        wr_sel[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= bus.reg_write_data;
                end
            end
        end
    end

    // No write-through: write data comes from these reads via the ALU, so a bypass would loop.
    assign bus.reg_read_data_1 = (bus.reg_read_addr_1 == '0) ? '0 : regs[bus.reg_read_addr_1];
    assign bus.reg_read_data_2 = (bus.reg_read_addr_2 == '0) ? '0 : regs[bus.reg_read_addr_2];
    assign bus.dbg_read_data   = (bus.dbg_read_addr   == '0) ? '0 : regs[bus.dbg_read_addr];
endmodule
